// File: rtl/prbs_checker.sv
// prbs_checker
//   Serial PRBS checker for the Fibonacci LFSR stream. Each valid bit is
//   the LFSR feedback bit (the new Q[1]). The checker first loads its
//   reference register from the stream (SEARCH). It then confirms
//   LOCK_CNT consecutive correct predictions (VERIFY). After that it runs
//   the reference as a free-running flywheel and counts bit errors
//   (LOCKED).
//
//   Optional feature, macro PRBS_CHK_ZERO_DET_EN:
//     If the reference becomes all zero in VERIFY or LOCKED, the checker
//     drops back to SEARCH and pulses zero_det. This stops a stuck-at-0
//     line from ever locking. Without the macro, zero_det is tied low.
//
// Parameters: N (8 or 3), LOCK_CNT, WINDOW, LOSS_THR, ERR_W
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   din_valid  din carries a stream bit this cycle
//   din        received stream bit
//   err_clr    synchronous clear of err_count
//   locked     checker is in LOCKED
//   err_pulse  one-cycle pulse per error detected while LOCKED
//   err_count  saturating error count
//   zero_det   all-zero reference detected (optional feature)
module prbs_checker #(
  parameter int N        = 8,
  parameter int LOCK_CNT = 16,
  parameter int WINDOW   = 64,
  parameter int LOSS_THR = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             zero_det
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WBITS_W = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_THR + 1);

  state_t             state;
  logic [1:N]         ref_reg;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [WBITS_W-1:0] win_bits;
  logic [WERR_W-1:0]  win_err;

  logic               pred;
  logic               mismatch;
  logic               shift_in;
  logic [1:N]         ref_next;
  logic               win_wrap;
  logic [WBITS_W-1:0] win_bits_next;
  logic [WERR_W-1:0]  win_err_base;
  logic [WERR_W-1:0]  win_err_next;
  logic               loss;
  logic [ERR_W-1:0]   err_base;
  logic [ERR_W-1:0]   err_inc;

  // The predicted next bit is the LFSR feedback computed from the reference.
  // Any register length without a known tap set stops elaboration.
  generate
    if (N == 8) begin : g_taps8
      assign pred = ref_reg[8] ^ ref_reg[6] ^ ref_reg[5] ^ ref_reg[4];
    end else if (N == 3) begin : g_taps3
      assign pred = ref_reg[3] ^ ref_reg[2];
    end else begin : g_bad_n
      $error("prbs_checker: N must be 8 or 3");
    end
  endgenerate

  // Next-state helpers, computed for the current valid bit:
  // - In LOCKED, the reference is fed from its own prediction (flywheel).
  //   A corrupted input bit therefore never enters the register, so it
  //   cannot cause later false errors.
  // - A full window restarts on the next valid bit. That bit becomes the
  //   first bit of the new window.
  // - err_clr acts first, then the increment. So a clear and an error in
  //   the same cycle leave the count at 1.
  always_comb begin
    mismatch      = din_valid && (din != pred);
    shift_in      = (state == LOCKED) ? pred : din;
    ref_next      = {shift_in, ref_reg[1:N-1]};
    win_wrap      = (win_bits == WBITS_W'(WINDOW));
    win_bits_next = win_wrap ? WBITS_W'(1) : win_bits + WBITS_W'(1);
    win_err_base  = win_wrap ? '0 : win_err;
    win_err_next  = win_err_base + (mismatch ? WERR_W'(1) : WERR_W'(0));
    loss          = mismatch && (win_err_base == WERR_W'(LOSS_THR - 1));
    err_base      = err_clr ? '0 : err_count;
    err_inc       = (err_base == {ERR_W{1'b1}}) ? err_base
                                                : err_base + ERR_W'(1);
  end

  // Checker FSM. The state, the reference, all counters and all outputs
  // live in this one block. Nothing moves on a cycle without din_valid,
  // except the err_clr path and the single-cycle pulses returning low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SEARCH;
      ref_reg   <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
`ifdef PRBS_CHK_ZERO_DET_EN
      zero_det  <= 1'b0;
`endif
    end else begin
      err_pulse <= 1'b0;
`ifdef PRBS_CHK_ZERO_DET_EN
      zero_det  <= 1'b0;
`endif
      if (err_clr) begin
        err_count <= '0;
      end
      if (din_valid) begin
        ref_reg <= ref_next;
        unique case (state)
          SEARCH: begin
            if (fill_cnt == FILL_W'(N - 1)) begin
              state     <= VERIFY;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + FILL_W'(1);
            end
          end
          VERIFY: begin
            if (mismatch) begin
              match_cnt <= '0;
            end else if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
              win_bits  <= '0;
              win_err   <= '0;
            end else begin
              match_cnt <= match_cnt + MATCH_W'(1);
            end
          end
          LOCKED: begin
            win_bits <= win_bits_next;
            win_err  <= win_err_next;
            if (mismatch) begin
              err_pulse <= 1'b1;
              err_count <= err_inc;
            end
            if (loss) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              fill_cnt <= '0;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
`ifdef PRBS_CHK_ZERO_DET_EN
        // An all-zero reference can never be a real maximal-length pattern.
        // Restart the search, but keep err_count.
        if ((state != SEARCH) && (ref_next == '0)) begin
          state     <= SEARCH;
          locked    <= 1'b0;
          fill_cnt  <= '0;
          match_cnt <= '0;
          win_bits  <= '0;
          win_err   <= '0;
          zero_det  <= 1'b1;
        end
`endif
      end
    end
  end

`ifndef PRBS_CHK_ZERO_DET_EN
  assign zero_det = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker
//   Directed bench for prbs_checker. The stream comes from a local copy of
//   the 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with Q=1. Bits can be
//   flipped at chosen stream indices.
//
//   Two checkers receive identical inputs:
//     - dut     : default parameters
//     - dut_sat : ERR_W=4, used for the saturation case
//
//   Expected values are worked out by hand from the stream indices.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        din_valid;
  logic        din;
  logic        err_clr;

  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        zero_det;

  logic        locked_s;
  logic        err_pulse_s;
  logic [3:0]  err_count_s;
  logic        zero_det_s;

  int checks      = 0;
  int errors      = 0;
  int pulses      = 0;
  int pulses_s    = 0;
  int zero_pulses = 0;
  int locked_seen = 0;

  logic [8:1] lfsr;

  prbs_checker dut (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .zero_det  (zero_det)
  );

  prbs_checker #(.ERR_W(4)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .err_clr   (err_clr),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s),
    .zero_det  (zero_det_s)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point. Counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  // Drive one clock of inputs, then sample the outputs 1 ns after the edge.
  // Pulses are tallied here so that no single-cycle event is missed.
  task automatic applyStimulus(input logic v, input logic d, input logic clr, input logic rst_n);
    reset     = rst_n;
    din_valid = v;
    din       = d;
    err_clr   = clr;
    @(posedge clk);
    #1;
    if (err_pulse)   pulses++;
    if (err_pulse_s) pulses_s++;
    if (zero_det)    zero_pulses++;
    if (locked)      locked_seen++;
  endtask

  // Next feedback bit of the local LFSR, without advancing it.
  function automatic logic nextBit();
    return lfsr[8] ^ lfsr[6] ^ lfsr[5] ^ lfsr[4];
  endfunction

  // Send the next LFSR bit as a valid bit, optionally inverted.
  task automatic streamBit(input logic flip, input logic clr);
    logic fb;
    fb   = nextBit();
    lfsr = {lfsr[7:1], fb};
    applyStimulus(1'b1, fb ^ flip, clr, 1'b1);
  endtask

  // Hold reset for two cycles, reseed the generator and clear the tallies.
  task automatic doReset();
    lfsr = 8'd1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulses      = 0;
    pulses_s    = 0;
    zero_pulses = 0;
    locked_seen = 0;
  endtask

  initial begin
    // Reset values
    doReset();
    checkOutput("rst_locked",    int'(locked),      0);
    checkOutput("rst_err_pulse", int'(err_pulse),   0);
    checkOutput("rst_err_count", int'(err_count),   0);
    checkOutput("rst_zero_det",  int'(zero_det),    0);
    checkOutput("rst_sat_count", int'(err_count_s), 0);

    // Clean stream: lock exactly after valid bit 24, no errors over 500 bits
    for (int i = 1; i <= 24; i++) begin
      streamBit(1'b0, 1'b0);
      if (i == 23) checkOutput("lock_pre_23", int'(locked), 0);
    end
    checkOutput("lock_at_24", int'(locked), 1);
    for (int i = 25; i <= 500; i++) streamBit(1'b0, 1'b0);
    checkOutput("clean_err_count", int'(err_count), 0);
    checkOutput("clean_pulses",    pulses,          0);
    checkOutput("clean_locked",    int'(locked),    1);

    // Single flipped bit at stream index 100
    doReset();
    for (int i = 1; i <= 99; i++) streamBit(1'b0, 1'b0);
    streamBit(1'b1, 1'b0);
    checkOutput("flip_pulse", int'(err_pulse), 1);
    checkOutput("flip_count", int'(err_count), 1);
    streamBit(1'b0, 1'b0);
    checkOutput("flip_pulse_low", int'(err_pulse), 0);
    for (int i = 0; i < 50; i++) streamBit(1'b0, 1'b0);
    checkOutput("flip_pulses_total", pulses,          1);
    checkOutput("flip_count_hold",   int'(err_count), 1);
    checkOutput("flip_locked",       int'(locked),    1);

    // Four errors in one window (bits 50,55,60,65) -> loss, then relock at 89
    doReset();
    for (int i = 1; i <= 65; i++) begin
      streamBit(logic'(i == 50 || i == 55 || i == 60 || i == 65), 1'b0);
      if (i == 64) checkOutput("loss_pre", int'(locked), 1);
    end
    checkOutput("loss_locked", int'(locked),    0);
    checkOutput("loss_pulse",  int'(err_pulse), 1);
    checkOutput("loss_count",  int'(err_count), 4);
    checkOutput("loss_pulses", pulses,          4);
    for (int i = 66; i <= 89; i++) begin
      streamBit(1'b0, 1'b0);
      if (i == 88) checkOutput("relock_pre", int'(locked), 0);
    end
    checkOutput("relock",       int'(locked),    1);
    checkOutput("relock_count", int'(err_count), 4);

    // din_valid toggling; the idle cycles carry the inverted next bit
    doReset();
    for (int i = 1; i <= 24; i++) begin
      streamBit(1'b0, 1'b0);
      if (i == 24) checkOutput("toggle_lock_24", int'(locked), 1);
      applyStimulus(1'b0, ~nextBit(), 1'b0, 1'b1);
      if (i == 23) checkOutput("toggle_pre_23", int'(locked), 0);
    end
    checkOutput("toggle_lock_48", int'(locked), 1);
    for (int i = 0; i < 40; i++) begin
      streamBit(1'b0, 1'b0);
      applyStimulus(1'b0, ~nextBit(), 1'b0, 1'b1);
    end
    checkOutput("toggle_err_count", int'(err_count), 0);
    checkOutput("toggle_pulses",    pulses,          0);
    checkOutput("toggle_locked",    int'(locked),    1);

    // err_clr in the same cycle as a counted error gives a count of 1
    streamBit(1'b1, 1'b0);
    checkOutput("clr_first_err", int'(err_count), 1);
    for (int i = 0; i < 3; i++) streamBit(1'b0, 1'b0);
    streamBit(1'b1, 1'b1);
    checkOutput("clr_with_err",       int'(err_count),   1);
    checkOutput("clr_with_err_pulse", int'(err_pulse),   1);
    checkOutput("clr_with_err_sat",   int'(err_count_s), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_alone",        int'(err_count), 0);
    checkOutput("clr_alone_locked", int'(locked),    1);

    // Saturation: 20 isolated errors, every 22nd bit, at most 3 per window
    doReset();
    for (int i = 1; i <= 24; i++) streamBit(1'b0, 1'b0);
    for (int k = 1; k <= 440; k++) streamBit(logic'((k % 22) == 0), 1'b0);
    checkOutput("sat_count",       int'(err_count_s), 15);
    checkOutput("sat_pulses",      pulses_s,          20);
    checkOutput("sat_wide_count",  int'(err_count),   20);
    checkOutput("sat_locked",      int'(locked_s),    1);
    checkOutput("sat_wide_locked", int'(locked),      1);

    // Reset while locked, with a wrong valid bit on the same edge
    applyStimulus(1'b1, ~nextBit(), 1'b1, 1'b0);
    checkOutput("midrst_locked",    int'(locked),      0);
    checkOutput("midrst_err_pulse", int'(err_pulse),   0);
    checkOutput("midrst_err_count", int'(err_count),   0);
    checkOutput("midrst_zero_det",  int'(zero_det),    0);
    checkOutput("midrst_sat_count", int'(err_count_s), 0);

    // All-zero input stream with constant valid
    doReset();
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
`ifndef PRBS_CHK_ZERO_DET_EN
      if (i == 23) checkOutput("zero_lock_pre", int'(locked), 0);
      if (i == 24) checkOutput("zero_lock_24",  int'(locked), 1);
`endif
    end
`ifdef PRBS_CHK_ZERO_DET_EN
    checkOutput("zero_det_pulses", zero_pulses, 4);
    checkOutput("zero_never_lock", locked_seen, 0);
`else
    checkOutput("zero_det_tied", zero_pulses,  0);
    checkOutput("zero_locked",   int'(locked), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
